serial_alu_ctrl: RTL and testbench

//  Bit-serial ALU sequencer: computes one WIDTH-bit ALU op by time-sharing a single

---
 rtl/serial_alu_ctrl_if.sv | 27 ++
 rtl/serial_alu_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial ALU sequencer.
// The master side (decoder) issues start with operands and control; the
// slave side (sequencer) answers with busy/done and the registered result.
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ALU_control_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport slave (
        input  start_i, src1_i, src2_i, ALU_control_i,
        output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

    modport master (
        output start_i, src1_i, src2_i, ALU_control_i,
        input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one WIDTH-bit operation is evaluated LSB first by
// a single 1-bit ALU slice over WIDTH cycles, followed by a fix-up cycle that
// resolves SLT and registers the flags, and a done cycle.
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    serial_alu_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
        logic       is_slt;
        logic       is_arith;   // ADD/SUB: flags are reported
        logic       valid;
    } dec_t;

    // Control code to slice drive; unknown codes drive nothing and yield zero.
    function automatic dec_t decode(input logic [3:0] code);
        dec_t d;
        d = '0;
        d.valid = 1'b1;
        case (code)
            4'b0000: d.op = 2'b00;
            4'b0001: d.op = 2'b01;
            4'b0010: begin d.op = 2'b10; d.is_arith = 1'b1; end
            4'b0110: begin d.op = 2'b10; d.b_inv = 1'b1; d.is_arith = 1'b1; end
            4'b1100: begin d.op = 2'b00; d.a_inv = 1'b1; d.b_inv = 1'b1; end
            4'b0111: begin d.op = 2'b10; d.b_inv = 1'b1; d.is_slt = 1'b1; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [3:0]       ctrl;
    logic [CW-1:0]    cnt;
    logic             carry, msb_sum, msb_ovf;
    logic             busy, done, zero, cout, ovf;
    logic [WIDTH-1:0] result;

    dec_t             dec_run, dec_new;
    logic             sa, sb, s_sum, s_cout, slice_out, res_bit;
    logic [WIDTH-1:0] fix_result;

    assign dec_run = decode(ctrl);
    assign dec_new = decode(bus.ALU_control_i);

    // The single 1-bit ALU slice; carry flop feeds cin (preset to B_invert for bit 0).
    always_comb begin
        sa        = a_sh[0] ^ dec_run.a_inv;
        sb        = b_sh[0] ^ dec_run.b_inv;
        s_sum     = sa ^ sb ^ carry;
        s_cout    = (sa & sb) | (sa & carry) | (sb & carry);
        slice_out = 1'b0;
        case (dec_run.op)
            2'b00:   slice_out = sa & sb;
            2'b01:   slice_out = sa | sb;
            2'b10:   slice_out = s_sum;
            default: slice_out = 1'b0;   // less input is tied low
        endcase
        res_bit = (dec_run.is_slt || !dec_run.valid) ? 1'b0 : slice_out;
    end

    // Final result selection applied in the fix-up cycle.
    always_comb begin
        fix_result = '0;
        if (dec_run.is_slt)
            fix_result[0] = msb_sum ^ msb_ovf;
        else if (dec_run.valid)
            fix_result = res_sh;
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            ctrl    <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            msb_sum <= 1'b0;
            msb_ovf <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // The done cycle itself never accepts a new request.
                    if (bus.start_i && !done) begin
                        a_sh  <= bus.src1_i;
                        b_sh  <= bus.src2_i;
                        ctrl  <= bus.ALU_control_i;
                        cnt   <= '0;
                        carry <= dec_new.b_inv;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {res_bit, res_sh[WIDTH-1:1]};
                    carry  <= s_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        msb_sum <= s_sum;
                        msb_ovf <= carry ^ s_cout;
                        state   <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_result;
                    zero   <= (fix_result == '0);
                    cout   <= dec_run.is_arith ? carry : 1'b0;
                    ovf    <= dec_run.is_arith ? msb_ovf : 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.result_o   = result;
    assign bus.zero_o     = zero;
    assign bus.cout_o     = cout;
    assign bus.overflow_o = ovf;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: table of op vectors with a
// scoreboard queue, plus sequences for held start and mid-run reset.
module tb_serial_alu_ctrl;
    localparam int WIDTH = 32;
    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                           C_SUB = 4'b0110, C_NOR = 4'b1100, C_SLT = 4'b0111,
                           C_BAD = 4'b0011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus();
    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request for a single cycle and record its expected outcome.
    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input exp_t e);
        @(posedge clk);
        #1;
        bus.ALU_control_i = c;
        bus.src1_i = a;
        bus.src2_i = b;
        bus.start_i = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);   // start edge
        #1;
        bus.start_i = 1'b0;
        bus.src1_i = ~a;  // operands may change freely after the start edge
        bus.src2_i = ~b;
        check("busy_rise", 32'(bus.busy_o), 32'd1);
    endtask

    // Wait (bounded) for done, check latency and pulse shape, pop and compare.
    task automatic finish_op(input string tag, input bit check_lat);
        int   lat;
        exp_t e;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        if (check_lat) check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 2));
        e = sb_q.pop_front();
        check({tag, "_result"}, bus.result_o, e.res);
        check({tag, "_zero"}, 32'(bus.zero_o), 32'(e.z));
        check({tag, "_cout"}, 32'(bus.cout_o), 32'(e.c));
        check({tag, "_ovf"}, 32'(bus.overflow_o), 32'(e.o));
        check({tag, "_busy_at_done"}, 32'(bus.busy_o), 32'd0);
        $display("op %s: result=0x%08h zero=%0d cout=%0d ovf=%0d latency=%0d",
                 tag, bus.result_o, bus.zero_o, bus.cout_o, bus.overflow_o, lat);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(bus.done_o), 32'd0);
        check({tag, "_result_held"}, bus.result_o, e.res);
    endtask

    initial begin
        exp_t e;
        int   pulses;
        int   lat;
        bit   accepted;

        vecs[0]  = '{C_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{C_SUB, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{C_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{C_SLT, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{C_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{C_SLT, 32'd7,        32'd3,        32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{C_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{C_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{C_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{C_BAD, 32'd5,        32'd3,        32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{C_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{C_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};

        bus.start_i = 1'b0;
        bus.src1_i = '0;
        bus.src2_i = '0;
        bus.ALU_control_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_zero", 32'(bus.zero_o), 32'd1);
        check("rst_cout", 32'(bus.cout_o), 32'd0);
        check("rst_ovf", 32'(bus.overflow_o), 32'd0);
        rst_n = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            e = '{vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].o};
            start_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, e);
            finish_op($sformatf("vec%0d", i), 1'b1);
        end

        // start_i held high with operands changing during RUN
        @(posedge clk);
        #1;
        bus.ALU_control_i = C_ADD;
        bus.src1_i = 32'd2;
        bus.src2_i = 32'd3;
        bus.start_i = 1'b1;
        sb_q.push_back('{32'd5, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        pulses = 0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            bus.src1_i = $urandom;
            bus.src2_i = $urandom;
            bus.ALU_control_i = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                pulses++;
                lat = k;
                break;
            end
        end
        check("hold_latency", 32'(lat), 32'(WIDTH + 2));
        if (lat > 0) begin
            e = sb_q.pop_front();
            check("hold_result", bus.result_o, e.res);
            check("hold_busy_at_done", 32'(bus.busy_o), 32'd0);
            $display("op hold: result=0x%08h latency=%0d", bus.result_o, lat);
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        // Still holding start: the next request must be accepted after the done cycle.
        bus.ALU_control_i = C_ADD;
        bus.src1_i = 32'd10;
        bus.src2_i = 32'd20;
        sb_q.push_back('{32'd30, 1'b0, 1'b0, 1'b0});
        accepted = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) pulses++;
            if (bus.busy_o) begin
                accepted = 1'b1;
                break;
            end
        end
        bus.start_i = 1'b0;
        check("hold_single_pulse", 32'(pulses), 32'd1);
        check("hold_next_accepted", 32'(accepted), 32'd1);
        finish_op("hold_next", 1'b0);

        // Reset in the middle of RUN
        start_op(C_ADD, 32'd100, 32'd200, '{32'd300, 1'b0, 1'b0, 1'b0});
        void'(sb_q.pop_back());   // this op is aborted and never completes
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_done", 32'(bus.done_o), 32'd0);
        check("abort_result", bus.result_o, 32'd0);
        check("abort_zero", 32'(bus.zero_o), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o || bus.busy_o) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        $display("op abort: busy=%0d result=0x%08h zero=%0d", bus.busy_o, bus.result_o, bus.zero_o);
        start_op(C_ADD, 32'd2, 32'd3, '{32'd5, 1'b0, 1'b0, 1'b0});
        finish_op("after_abort", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
